regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
// - Parametrised integer register file with in-flight-writer scoreboard, NREAD read / NWRITE write ports.
// - Replaces the fixed 2R/1W RF array and reg_busy vector in the pipelined core.
// - Decode issues rd reservations; writeback ports commit data and release them.
// - Exports the post-write architectural state for difftest register snapshots.
// PARAMETERS
// XLEN    64  data width per register
// NREG    32  architectural registers (power of 2); AW = $clog2(NREG)
// NREAD   2   read ports
// NWRITE  1   write (writeback) ports
// CNT_W   2   width of per-register in-flight writer counter
// PORTS
// clk          in   1             clock
// reset        in   1             synchronous, active-high reset
// raddr        in   NREAD*AW      read addresses, port i at [i*AW +: AW]
// rdata        out  NREAD*XLEN    read data, combinational
// rbusy        out  NREAD         1 = pending writer for raddr[i]
// issue_valid  in   1             reserve issue_rd for one new in-flight writer
// issue_rd     in   AW            destination register being reserved
// issue_ready  out  1             0 = issue_rd counter saturated; issue refused
// wen          in   NWRITE        write enable per write port
// waddr        in   NWRITE*AW     write addresses
// wdata        in   NWRITE*XLEN   write data
// flush        in   1             drop all reservations (pipeline squash)
// arch_state   out  NREG*XLEN     register values after this cycle's writes (difftest)
// BEHAVIOUR
// - One clock, synchronous active-high reset: all registers <= 0, all counters <= 0.
//   Post-reset outputs: rdata = 0, rbusy = 0, issue_ready = 1, arch_state = 0.
// - x0: reads return 0, rbusy = 0; writes to x0 dropped; issue with issue_rd = 0 accepted, no effect.
// - Write: on clk edge with wen[j] && waddr[j] != 0, reg[waddr[j]] <= wdata[j].
//   Same-cycle writes to one address: highest port index j wins.
// - Read, no bypass: rdata[i] = reg[raddr[i]] (value before this cycle's writes); 1-cycle write-to-read latency.
// - arch_state always reflects post-write next state (same-cycle writes applied, same priority).
// - Counter cnt[r], CNT_W bits. Per clk, r != 0:
//   cnt_next = cnt + (issue accepted to r) - (number of write ports with wen && waddr == r).
//   Result clamped at 0 (writes from untracked sources allowed, no underflow).
// - issue_ready = (cnt[issue_rd] != 2^CNT_W-1) || issue_rd == 0. Combinational.
//   issue_valid && !issue_ready: no change.
//   Same-cycle release to the saturated rd does not raise issue_ready.
// - rbusy[i] = cnt[raddr[i]] != 0 (registered counters; issue visible next cycle).
// - flush: all cnt <= 0 next edge.
//   Flush wins over same-cycle issue; same-cycle writes still commit data.
// - Reset asserted mid-operation overrides flush, issue and writes in that cycle.
// - No FSM beyond counters; all state updates on posedge clk only.
// CONFIGURATION
// RF_BYPASS_EN defined:
// - rdata[i] takes the same-cycle write data to raddr[i] (highest port wins); 0-cycle write-to-read.
// - rbusy[i] = (cnt[raddr[i]] - same-cycle releases, clamped at 0) != 0.
//   A completing last writer reads as not busy in the same cycle.
// RF_BYPASS_EN undefined:
// - Reads see registered state only; rbusy from registered counters.
// - One extra stall cycle per RAW hazard.
// TESTING
// T1 reset; read x0..x31 -> all rdata=0, rbusy=0, issue_ready=1; write x0=0xDEAD -> next cycle x0 reads 0.
// T2 wen0 x5=0x1234 -> same cycle: arch_state[5]=0x1234, rdata(x5)=0 (no bypass) / 0x1234 (bypass);
//    next cycle: 0x1234 in both builds.
// T3 NWRITE=2: ports 0/1 write x7=0xA / 0xB same cycle -> x7=0xB.
//    Issue x7 twice then one write -> rbusy=1; second write -> rbusy=0.
// T4 CNT_W=2: issue x3 three times -> issue_ready=0.
//    4th issue ignored; one release -> issue_ready=1 next cycle.
// T5 issue x9 and x10, then flush + wen x4=0x55 same cycle -> next cycle rbusy(x9,x10)=0, x4=0x55.
//    Flush + issue x11 same cycle -> x11 not busy.
// T6 write x6 with cnt=0 -> cnt stays 0, data written.
//    Reset mid-burst (issue x2, wen x2=0x99 same cycle) -> x2=0, not busy.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//   Integer register file with a per-register in-flight-writer scoreboard.
//   Decode reserves a destination through the issue port. Writeback ports
//   commit data and release one reservation each. arch_state exports the
//   register values as they will be after this cycle's writes.
//
// Parameters
//   XLEN   data width per register
//   NREG   number of architectural registers (power of 2), AW = $clog2(NREG)
//   NREAD  read ports
//   NWRITE write ports
//   CNT_W  width of each in-flight writer counter
//
// Ports
//   clk, reset    clock and synchronous active-high reset
//   raddr/rdata   combinational read ports (port i at [i*AW +: AW] / [i*XLEN +: XLEN])
//   rbusy         per read port: a writer is still pending for raddr[i]
//   issue_valid/issue_rd/issue_ready   rd reservation handshake
//   wen/waddr/wdata                    writeback ports (highest index wins)
//   flush         drop all reservations
//   arch_state    post-write register image, register r at [r*XLEN +: XLEN]
//
// Handshake: an issue takes effect on a clock edge exactly when issue_valid
// and issue_ready are both 1. issue_ready depends only on issue_rd and the
// registered counters, never on issue_valid, so there is no combinational loop.
//
// Configuration macro RF_BYPASS_EN: when defined, reads forward same-cycle
// write data and rbusy discounts same-cycle releases.
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1,
  parameter int CNT_W  = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*XLEN-1:0]  rdata,
  output logic [NREAD-1:0]       rbusy,
  input  logic                   issue_valid,
  input  logic [AW-1:0]          issue_rd,
  output logic                   issue_ready,
  input  logic [NWRITE-1:0]      wen,
  input  logic [NWRITE*AW-1:0]   waddr,
  input  logic [NWRITE*XLEN-1:0] wdata,
  input  logic                   flush,
  output logic [NREG*XLEN-1:0]   arch_state
);

  // Wide enough to hold a counter plus one issue and to count all releases
  // without wrapping, so the clamp at zero can be done with one compare.
  localparam int SW = CNT_W + $clog2(NWRITE + 1) + 1;

  logic [XLEN-1:0]  regs      [NREG];
  logic [CNT_W-1:0] cnt       [NREG];
  logic [XLEN-1:0]  next_regs [NREG];
  logic [CNT_W-1:0] cnt_next  [NREG];
  logic [SW-1:0]    rel       [NREG];
  logic [SW-1:0]    up        [NREG];
  logic             issue_acc;

  // x0 never reserves, so it is always ready.
  assign issue_ready = (issue_rd == '0) || (cnt[issue_rd] != {CNT_W{1'b1}});
  assign issue_acc   = issue_valid && issue_ready && (issue_rd != '0);

  always_comb begin
    arch_state = '0;
    for (int r = 0; r < NREG; r++) begin
      next_regs[r] = regs[r];
      rel[r]       = '0;
      for (int j = 0; j < NWRITE; j++) begin
        if (wen[j] && (waddr[j*AW +: AW] == AW'(r))) begin
          // Later ports overwrite earlier ones: highest index wins.
          next_regs[r] = wdata[j*XLEN +: XLEN];
          rel[r]       = rel[r] + SW'(1);
        end
      end
      up[r] = SW'(cnt[r]) + SW'(issue_acc && (issue_rd == AW'(r)));
      // Releases from writers that were never reserved clamp at zero.
      cnt_next[r] = (up[r] > rel[r]) ? CNT_W'(up[r] - rel[r]) : '0;
      if (r == 0) begin
        next_regs[r] = '0;
        cnt_next[r]  = '0;
      end
      arch_state[r*XLEN +: XLEN] = next_regs[r];
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NREAD; i++) begin
`ifdef RF_BYPASS_EN
      rdata[i*XLEN +: XLEN] = next_regs[raddr[i*AW +: AW]];
      rbusy[i] = SW'(cnt[raddr[i*AW +: AW]]) > rel[raddr[i*AW +: AW]];
`else
      rdata[i*XLEN +: XLEN] = regs[raddr[i*AW +: AW]];
      rbusy[i] = cnt[raddr[i*AW +: AW]] != '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= next_regs[r];
        // Flush drops reservations but writes still commit above.
        cnt[r]  <= flush ? '0 : cnt_next[r];
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
//   Directed bench for regfile_scoreboard configured with 2 read and 2 write
//   ports. Inputs change 1 ns after the rising edge; outputs are sampled 1 ns
//   later. Expected values are hand-computed; bypass-dependent values follow
//   RF_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [9:0]   raddr;
  logic [127:0] rdata;
  logic [1:0]   rbusy;
  logic         issue_valid;
  logic [4:0]   issue_rd;
  logic         issue_ready;
  logic [1:0]   wen;
  logic [9:0]   waddr;
  logic [127:0] wdata;
  logic         flush;
  logic [2047:0] arch_state;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(
    .XLEN(64), .NREG(32), .NREAD(2), .NWRITE(2), .CNT_W(2)
  ) dut (
    .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wen(wen), .waddr(waddr), .wdata(wdata), .flush(flush),
    .arch_state(arch_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rd(input int p);
    return rdata[p*64 +: 64];
  endfunction

  function automatic logic [63:0] arch(input int r);
    return arch_state[r*64 +: 64];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen         = 2'b00;
    waddr       = '0;
    wdata       = '0;
    issue_valid = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic set_r(input int p, input logic [4:0] a);
    raddr[p*5 +: 5] = a;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [63:0] d);
    wen[p]           = 1'b1;
    waddr[p*5 +: 5]  = a;
    wdata[p*64 +: 64] = d;
  endtask

  task automatic issue(input logic [4:0] a);
    issue_valid = 1'b1;
    issue_rd    = a;
  endtask

  initial begin
    // T1: reset
    reset = 1'b1; raddr = '0; issue_rd = '0; idle();
    tick(); tick();
    reset = 1'b0;
    for (int a = 0; a < 32; a += 2) begin
      set_r(0, 5'(a)); set_r(1, 5'(a + 1));
      #1;
      chk($sformatf("t1_rdata_x%0d", a), rd(0), 64'h0);
      chk($sformatf("t1_rdata_x%0d", a + 1), rd(1), 64'h0);
      chk($sformatf("t1_rbusy_x%0d", a), {62'h0, rbusy}, 64'h0);
    end
    issue_rd = 5'd5; #1;
    chk("t1_issue_ready", {63'h0, issue_ready}, 64'h1);
    chk("t1_arch_zero", {63'h0, (arch_state == '0)}, 64'h1);
    tick();
    wr(0, 5'd0, 64'hDEAD); set_r(0, 5'd0); #1;
    chk("t1_x0_same_cycle", rd(0), 64'h0);
    chk("t1_x0_arch", arch(0), 64'h0);
    tick(); idle(); #1;
    chk("t1_x0_after", rd(0), 64'h0);

    // T2: write latency
    tick();
    wr(0, 5'd5, 64'h1234); set_r(0, 5'd5); #1;
    chk("t2_arch_x5", arch(5), 64'h1234);
    chk("t2_rdata_same", rd(0), BYP ? 64'h1234 : 64'h0);
    tick(); idle(); #1;
    chk("t2_rdata_next", rd(0), 64'h1234);

    // T3: two write ports, counter release
    tick();
    wr(0, 5'd7, 64'hA); wr(1, 5'd7, 64'hB); #1;
    chk("t3_arch_prio", arch(7), 64'hB);
    tick(); idle(); set_r(0, 5'd7); #1;
    chk("t3_rdata_prio", rd(0), 64'hB);
    issue(5'd7);
    tick(); tick(); idle(); #1;
    chk("t3_busy_cnt2", {63'h0, rbusy[0]}, 64'h1);
    wr(0, 5'd7, 64'hC); #1;
    chk("t3_busy_rel1_same", {63'h0, rbusy[0]}, 64'h1);
    tick(); idle(); #1;
    chk("t3_busy_cnt1", {63'h0, rbusy[0]}, 64'h1);
    chk("t3_rdata_c", rd(0), 64'hC);
    wr(0, 5'd7, 64'hD); #1;
    chk("t3_busy_rel2_same", {63'h0, rbusy[0]}, BYP ? 64'h0 : 64'h1);
    tick(); idle(); #1;
    chk("t3_busy_cnt0", {63'h0, rbusy[0]}, 64'h0);

    // T4: saturation
    issue(5'd3); #1;
    chk("t4_ready_cnt0", {63'h0, issue_ready}, 64'h1);
    tick(); tick(); tick(); #1;
    chk("t4_ready_cnt3", {63'h0, issue_ready}, 64'h0);
    tick(); issue_valid = 1'b0; #1;
    chk("t4_ready_after_4th", {63'h0, issue_ready}, 64'h0);
    issue(5'd3); wr(0, 5'd3, 64'h33); #1;
    chk("t4_ready_rel_same", {63'h0, issue_ready}, 64'h0);
    tick(); idle(); set_r(1, 5'd3); #1;
    chk("t4_ready_after_rel", {63'h0, issue_ready}, 64'h1);
    chk("t4_busy_x3", {63'h0, rbusy[1]}, 64'h1);

    // T5: flush
    issue(5'd9); tick();
    issue(5'd10); tick(); idle();
    set_r(0, 5'd9); set_r(1, 5'd10); #1;
    chk("t5_busy_pre", {62'h0, rbusy}, 64'h3);
    flush = 1'b1; wr(0, 5'd4, 64'h55);
    tick(); idle(); #1;
    chk("t5_busy_post", {62'h0, rbusy}, 64'h0);
    set_r(0, 5'd4); set_r(1, 5'd3); #1;
    chk("t5_x4_data", rd(0), 64'h55);
    chk("t5_x3_cleared", {63'h0, rbusy[1]}, 64'h0);
    flush = 1'b1; issue(5'd11);
    tick(); idle(); set_r(0, 5'd11); #1;
    chk("t5_x11_not_busy", {63'h0, rbusy[0]}, 64'h0);

    // T6: untracked write, reset mid-burst
    wr(0, 5'd6, 64'h66);
    tick(); idle(); set_r(0, 5'd6); #1;
    chk("t6_x6_data", rd(0), 64'h66);
    chk("t6_x6_not_busy", {63'h0, rbusy[0]}, 64'h0);
    issue(5'd6);
    tick(); idle(); #1;
    chk("t6_x6_busy_one", {63'h0, rbusy[0]}, 64'h1);
    issue(5'd2); wr(0, 5'd2, 64'h99); reset = 1'b1;
    tick(); reset = 1'b0; idle(); set_r(0, 5'd2); set_r(1, 5'd5); #1;
    chk("t6_x2_data", rd(0), 64'h0);
    chk("t6_x2_not_busy", {63'h0, rbusy[0]}, 64'h0);
    chk("t6_x5_cleared", rd(1), 64'h0);
    chk("t6_arch_x6", arch(6), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
